// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared state encoding and step-count helper for the systolic feeder
package systolic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam int DEFAULT_N = 3;

    // Enabled streaming cycles for an N x N array: skew fill plus drain.
    function automatic int step_count(input int n);
        return 3 * n - 2;
    endfunction

    localparam int STEP_COUNT = step_count(DEFAULT_N);

endpackage

// File: rtl/skew_lane.sv
// rtl/skew_lane.sv - picks operand (t - lane) from one row/column, or zero outside the skew window
module skew_lane
    import systolic_pkg::*;
#(
    parameter int W  = 32,
    parameter int N  = 3,
    parameter int TW = $clog2(step_count(N) + 1)
) (
    input  logic [N*W-1:0] ops,
    input  logic [TW-1:0]  lane,
    input  logic [TW-1:0]  t,
    output logic [W-1:0]   operand
);

    logic [TW-1:0] d;

    always_comb begin
        d       = t - lane;
        operand = '0;
        if (t >= lane) begin
            for (int k = 0; k < N; k++) begin
                if (d == TW'(k)) begin
                    operand = ops[k*W +: W];
                end
            end
        end
    end

endmodule

// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - captures an A/B matrix pair and streams skewed operands into an N x N array
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int W = 32,
    parameter int N = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [W*N*N-1:0] i_A_mat,
    input  logic [W*N*N-1:0] i_B_mat,
    input  logic             i_hold,
    output logic [W*N-1:0]   o_A,
    output logic [W*N-1:0]   o_B,
    output logic             o_en,
    output logic             o_clr,
    output logic             o_done
);

    localparam int            STEPS  = step_count(N);
    localparam int            TW     = $clog2(STEPS + 1);
    localparam logic [TW-1:0] T_LAST = TW'(STEPS - 1);

    state_t           state_q, state_d;
    logic [TW-1:0]    t_q, t_d, t_issue;
    logic             capture, issue, en_d, clr_d, done_d;
    logic [W*N*N-1:0] a_q, b_q;
    logic [W*N-1:0]   lanes_a, lanes_b;

    // Outputs are registered, so the step loaded on an edge is the one shown next cycle.
    assign t_issue = (state_q == ST_RUN) ? t_q + TW'(1) : '0;
    assign o_ready = (state_q == ST_IDLE);

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [N*W-1:0] col;
        for (genvar k = 0; k < N; k++) begin : g_col
            assign col[k*W +: W] = b_q[(k*N+i)*W +: W];
        end

        skew_lane #(.W(W), .N(N), .TW(TW)) u_a (
            .ops     (a_q[i*N*W +: N*W]),
            .lane    (TW'(i)),
            .t       (t_issue),
            .operand (lanes_a[i*W +: W])
        );

        skew_lane #(.W(W), .N(N), .TW(TW)) u_b (
            .ops     (col),
            .lane    (TW'(i)),
            .t       (t_issue),
            .operand (lanes_b[i*W +: W])
        );
    end

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        capture = 1'b0;
        issue   = 1'b0;
        en_d    = 1'b0;
        clr_d   = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    capture = 1'b1;
                    clr_d   = 1'b1;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                issue   = 1'b1;
                en_d    = 1'b1;
                t_d     = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!i_hold) begin
                    if (t_q == T_LAST) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        issue = 1'b1;
                        en_d  = 1'b1;
                        t_d   = t_q + TW'(1);
                    end
                end
            end
            ST_DONE: begin
                t_d     = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            t_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            o_A     <= '0;
            o_B     <= '0;
            o_en    <= 1'b0;
            o_clr   <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            o_en    <= en_d;
            o_clr   <= clr_d;
            o_done  <= done_d;
            if (capture) begin
                a_q <= i_A_mat;
                b_q <= i_B_mat;
            end
            if (issue) begin
                o_A <= lanes_a;
                o_B <= lanes_b;
            end
        end
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// tb/tb_systolic_feeder.sv - directed self-checking bench for systolic_feeder with a 3x3 array model
module tb_systolic_feeder;

    localparam int W = 8;
    localparam int N = 3;
    localparam logic [71:0] A_SEQ  = 72'h090807060504030201;
    localparam logic [71:0] B_ID   = 72'h010000000100000001;
    localparam logic [71:0] A_ALT  = 72'h555555555555555555;

    logic             i_clk = 1'b0;
    logic             i_rst_n = 1'b0;
    logic             i_valid = 1'b0;
    logic             i_hold = 1'b0;
    logic [W*N*N-1:0] i_A_mat = '0;
    logic [W*N*N-1:0] i_B_mat = '0;
    logic             o_ready;
    logic [W*N-1:0]   o_A;
    logic [W*N-1:0]   o_B;
    logic             o_en;
    logic             o_clr;
    logic             o_done;

    systolic_feeder #(.W(W), .N(N)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_A_mat (i_A_mat),
        .i_B_mat (i_B_mat),
        .i_hold  (i_hold),
        .o_A     (o_A),
        .o_B     (o_B),
        .o_en    (o_en),
        .o_clr   (o_clr),
        .o_done  (o_done)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Downstream output-stationary 3x3 array fed by the DUT.
    logic [7:0]  pa [3][3];
    logic [7:0]  pb [3][3];
    logic [31:0] acc[3][3];

    function automatic logic [7:0] a_in(input int i, input int j);
        return (j == 0) ? o_A[i*8 +: 8] : pa[i][j-1];
    endfunction

    function automatic logic [7:0] b_in(input int i, input int j);
        return (i == 0) ? o_B[j*8 +: 8] : pb[i-1][j];
    endfunction

    always @(posedge i_clk) begin
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                if (o_clr) begin
                    acc[i][j] <= '0;
                    pa[i][j]  <= '0;
                    pb[i][j]  <= '0;
                end else if (o_en) begin
                    acc[i][j] <= acc[i][j] + 32'(a_in(i, j)) * 32'(b_in(i, j));
                    pa[i][j]  <= a_in(i, j);
                    pb[i][j]  <= b_in(i, j);
                end
            end
        end
    end

    function automatic logic [31:0] exp_c(input logic [71:0] am, input logic [71:0] bm,
                                          input int i, input int j);
        logic [31:0] s;
        s = '0;
        for (int k = 0; k < 3; k++) begin
            s = s + 32'(am[(i*3+k)*8 +: 8]) * 32'(bm[(k*3+j)*8 +: 8]);
        end
        return s;
    endfunction

    typedef struct {
        logic [71:0] a_mat;
        logic [71:0] b_mat;
        int          t;
        logic [23:0] ea;
        logic [23:0] eb;
    } vec_t;

    vec_t        vt[14];
    logic [23:0] obs_a[16];
    logic [23:0] obs_b[16];
    int          clr_cyc, en_cyc, done_cyc, steps, frozen;

    // Starts on a negedge with o_ready high; cycle numbers count from the accept edge.
    task automatic do_op(input logic [71:0] am, input logic [71:0] bm,
                         input int hold_at, input int hold_len);
        int          cyc;
        int          hold_left;
        logic [23:0] frz_a, frz_b;
        clr_cyc = -1; en_cyc = -1; done_cyc = -1; steps = 0; frozen = 0; hold_left = 0;
        frz_a = '0; frz_b = '0;
        i_A_mat = am;
        i_B_mat = bm;
        i_valid = 1'b1;
        chk("ready_before_accept", 64'(o_ready), 64'(1));
        @(negedge i_clk);
        i_valid = 1'b0;
        cyc = 1;
        while (cyc < 40 && done_cyc < 0) begin
            if (o_clr && clr_cyc < 0) clr_cyc = cyc;
            if (o_done) begin
                done_cyc = cyc;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        chk($sformatf("array_c%0d%0d", i, j), 64'(acc[i][j]), 64'(exp_c(am, bm, i, j)));
            end else if (o_en) begin
                if (en_cyc < 0) en_cyc = cyc;
                if (steps < 16) begin
                    obs_a[steps] = o_A;
                    obs_b[steps] = o_B;
                end
                if (steps == hold_at && hold_len > 0) begin
                    i_hold    = 1'b1;
                    hold_left = hold_len;
                    frz_a     = o_A;
                    frz_b     = o_B;
                end
                steps++;
            end else if (hold_left > 0) begin
                chk("hold_frozen_a", 64'(o_A), 64'(frz_a));
                chk("hold_frozen_b", 64'(o_B), 64'(frz_b));
                frozen++;
                hold_left--;
                if (hold_left == 0) i_hold = 1'b0;
            end
            if (done_cyc < 0) begin
                cyc++;
                @(negedge i_clk);
            end
        end
        i_hold = 1'b0;
        chk("done_seen", 64'(done_cyc >= 0), 64'(1));
        chk("done_in_done_cycle_ready", 64'(o_ready), 64'(0));
        @(negedge i_clk);
        chk("done_one_cycle", 64'(o_done), 64'(0));
        chk("ready_after_done", 64'(o_ready), 64'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          accepts[$];
        int          en_n, dones, waitc;
        logic [23:0] exp_a1[7];

        vt[0]  = '{A_SEQ, B_ID, 0, 24'h000001, 24'h000001};
        vt[1]  = '{A_SEQ, B_ID, 1, 24'h000402, 24'h000000};
        vt[2]  = '{A_SEQ, B_ID, 2, 24'h070503, 24'h000100};
        vt[3]  = '{A_SEQ, B_ID, 3, 24'h080600, 24'h000000};
        vt[4]  = '{A_SEQ, B_ID, 4, 24'h090000, 24'h010000};
        vt[5]  = '{A_SEQ, B_ID, 5, 24'h000000, 24'h000000};
        vt[6]  = '{A_SEQ, B_ID, 6, 24'h000000, 24'h000000};
        vt[7]  = '{{72{1'b1}}, {72{1'b1}}, 0, 24'h0000FF, 24'h0000FF};
        vt[8]  = '{{72{1'b1}}, {72{1'b1}}, 1, 24'h00FFFF, 24'h00FFFF};
        vt[9]  = '{{72{1'b1}}, {72{1'b1}}, 2, 24'hFFFFFF, 24'hFFFFFF};
        vt[10] = '{{72{1'b1}}, {72{1'b1}}, 3, 24'hFFFF00, 24'hFFFF00};
        vt[11] = '{{72{1'b1}}, {72{1'b1}}, 4, 24'hFF0000, 24'hFF0000};
        vt[12] = '{{72{1'b1}}, {72{1'b1}}, 5, 24'h000000, 24'h000000};
        vt[13] = '{{72{1'b1}}, {72{1'b1}}, 6, 24'h000000, 24'h000000};
        for (int i = 0; i < 7; i++) exp_a1[i] = vt[i].ea;

        // Reset state
        repeat (2) @(negedge i_clk);
        chk("rst_ready", 64'(o_ready), 64'(1));
        chk("rst_o_A", 64'(o_A), 64'(0));
        chk("rst_o_B", 64'(o_B), 64'(0));
        chk("rst_en", 64'(o_en), 64'(0));
        chk("rst_clr", 64'(o_clr), 64'(0));
        chk("rst_done", 64'(o_done), 64'(0));
        i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("ready_after_release", 64'(o_ready), 64'(1));

        // Table-driven skew vectors; each t==0 entry launches a fresh operation
        for (int v = 0; v < 14; v++) begin
            if (vt[v].t == 0) begin
                do_op(vt[v].a_mat, vt[v].b_mat, -1, 0);
                chk("lat_clr", 64'(clr_cyc), 64'(1));
                chk("lat_first_en", 64'(en_cyc), 64'(2));
                chk("lat_done", 64'(done_cyc), 64'(9));
                chk("en_steps", 64'(steps), 64'(7));
            end
            chk($sformatf("vec%0d_o_A_t%0d", v, vt[v].t), 64'(obs_a[vt[v].t]), 64'(vt[v].ea));
            chk($sformatf("vec%0d_o_B_t%0d", v, vt[v].t), 64'(obs_b[vt[v].t]), 64'(vt[v].eb));
        end

        // Two-cycle hold at t=1
        do_op(A_SEQ, B_ID, 1, 2);
        chk("hold_frozen_cycles", 64'(frozen), 64'(2));
        chk("hold_done_delay", 64'(done_cyc), 64'(11));
        chk("hold_en_steps", 64'(steps), 64'(7));
        chk("hold_o_A_t1", 64'(obs_a[1]), 64'(24'h000402));
        chk("hold_o_A_t2", 64'(obs_a[2]), 64'(24'h070503));
        chk("hold_o_B_t2", 64'(obs_b[2]), 64'(24'h000100));

        // Back-to-back with i_valid held high; i_A_mat changes mid-run
        i_A_mat = A_SEQ;
        i_B_mat = B_ID;
        i_valid = 1'b1;
        en_n = 0;
        for (int c = 0; c < 32; c++) begin
            if (o_ready) accepts.push_back(c);
            if (accepts.size() == 1) begin
                if (c == accepts[0] + 3) i_A_mat = A_ALT;
                if (o_en && en_n < 5) begin
                    chk($sformatf("b2b_o_A_t%0d", en_n), 64'(o_A), 64'(exp_a1[en_n]));
                    en_n++;
                end
            end
            @(negedge i_clk);
        end
        i_valid = 1'b0;
        chk("b2b_accept_count", 64'(accepts.size()), 64'(4));
        chk("b2b_enabled_seen", 64'(en_n), 64'(5));
        for (int k = 1; k < accepts.size(); k++)
            chk($sformatf("b2b_gap%0d", k), 64'(accepts[k] - accepts[k-1]), 64'(10));
        waitc = 0;
        while (!o_ready && waitc < 20) begin
            @(negedge i_clk);
            waitc++;
        end
        chk("b2b_drained", 64'(o_ready), 64'(1));

        // Reset abort at t=4
        i_A_mat = A_SEQ;
        i_B_mat = B_ID;
        i_valid = 1'b1;
        @(negedge i_clk);
        i_valid = 1'b0;
        en_n = 0;
        waitc = 0;
        while (en_n < 5 && waitc < 20) begin
            if (o_en) en_n++;
            if (en_n < 5) begin
                @(negedge i_clk);
                waitc++;
            end
        end
        chk("abort_reached_t4", 64'(en_n), 64'(5));
        i_rst_n = 1'b0;
        #1;
        chk("abort_o_A", 64'(o_A), 64'(0));
        chk("abort_o_B", 64'(o_B), 64'(0));
        chk("abort_en", 64'(o_en), 64'(0));
        chk("abort_clr", 64'(o_clr), 64'(0));
        chk("abort_done", 64'(o_done), 64'(0));
        chk("abort_ready", 64'(o_ready), 64'(1));
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("abort_ready_after_release", 64'(o_ready), 64'(1));
        dones = 0;
        for (int c = 0; c < 15; c++) begin
            if (o_done) dones++;
            @(negedge i_clk);
        end
        chk("abort_no_done", 64'(dones), 64'(0));
        chk("abort_idle", 64'(o_ready), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
